load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit placed between the EX/MEM pipeline register and `Data_Mem`. It turns a pipeline memory request into word-aligned `Data_Mem` accesses. Byte and halfword stores are done as a two-cycle read-modify-write, and load data is sign- or zero-extended. It also range- and alignment-checks every access and raises a fault pulse toward the hazard/exception logic.

## Interface
- `DATA_BASE`, 32'h10001000: first byte address of the data segment.
- `DATA_WORDS`, 256: data segment size in 32-bit words; valid bytes are `DATA_BASE` .. `DATA_BASE+4*DATA_WORDS-1`.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `ls_valid`  in  1  request present from EX/MEM
- `MemRead`  in  1  load request
- `MemWrite`  in  1  store request
- `ls_size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word
- `ls_unsigned`  in  1  zero-extend loads (lbu/lhu)
- `Address`  in  32  byte address
- `StoreData`  in  32  store operand, right-justified
- `dm_Address`  out  32  word-aligned address to `Data_Mem`
- `dm_WriteData`  out  32  write word to `Data_Mem`
- `dm_MemRead`  out  1  `Data_Mem` read strobe
- `dm_MemWrite`  out  1  `Data_Mem` write strobe; `Data_Mem` writes on the `clk` rising edge
- `dm_ReadData`  in  32  `Data_Mem` combinational read word
- `stall`  out  1  hold EX/MEM and upstream stages this cycle
- `LoadData`  out  32  extended load result, registered
- `load_valid`  out  1  one-cycle pulse marking `LoadData` as new
- `fault`  out  1  one-cycle pulse on a rejected request
- `fault_cause`  out  2  01 misaligned, 10 out of range, 11 read+write conflict
- `fault_addr`  out  32  `Address` of the faulting request

## Operation
- Byte order is big-endian: byte offset 0 is `[31:24]`; halfword offset 0 is `[31:16]`.
- `dm_Address` = {`Address[31:2]`, 2'b00} whenever the unit drives an access.
- **Request check.** A request is `ls_valid` & (`MemRead` | `MemWrite`). Checks are evaluated in IDLE in this priority order:
  - `MemRead` & `MemWrite` -> conflict (cause 11).
  - Halfword with `Address[0]`=1, or word with `Address[1:0]`≠0 -> misaligned (cause 01).
  - Address outside the data segment -> out of range (cause 10).
- **Faulting request.** No `dm_*` strobe is driven. At the next edge: `fault`=1, `fault_cause` and `fault_addr` are registered. `stall`=0.
- **Load.** In IDLE: `dm_MemRead`=1. At the edge, the selected byte/half/word of `dm_ReadData` is registered into `LoadData`, sign-extended unless `ls_unsigned`=1, and `load_valid`=1. `stall`=0.
- **Word store.** In IDLE: `dm_MemWrite`=1 and `dm_WriteData`=`StoreData` in the same cycle. `stall`=0.
- **Sub-word store.** The FSM has two states, IDLE and RMW_WR.
  - IDLE cycle: `dm_MemRead`=1 and `stall`=1. At the edge, `dm_ReadData` is latched into the merge register with the selected lane replaced by `StoreData[7:0]` or `StoreData[15:0]`. Next state is RMW_WR.
  - RMW_WR cycle: `dm_MemWrite`=1, `dm_WriteData`=merge register, `dm_Address` from the held `Address`, `stall`=0. New requests are not evaluated in this cycle. Next state is IDLE.
  - Upstream holds every request input stable while `stall`=1.
- When `ls_valid`=0, no strobes are driven and `load_valid` and `fault` stay 0.

## Timing
- **Reset** (`rst`=0, asynchronous):
  - State goes to IDLE.
  - `LoadData`=0, `load_valid`=0, `fault`=0, `fault_cause`=0, `fault_addr`=0, and the merge register is cleared.
  - `dm_MemRead`, `dm_MemWrite` and `stall` are forced to 0 combinationally while `rst`=0. A reset during RMW_WR aborts the write: no `Data_Mem` write occurs.
- **Latency**:
  - Load: `LoadData` is valid 1 cycle after the request cycle.
  - Word store: 1 cycle, no stall.
  - Sub-word store: 2 cycles, with exactly 1 stall cycle.
  - Fault: pulse 1 cycle after the request cycle.
- `load_valid` and `fault` are high for exactly one cycle per accepted request; back-to-back requests give back-to-back pulses.
- Load immediately after a sub-word store: the load is evaluated in the cycle after RMW_WR and reads the merged word.

## Test plan
- Reset asserted mid-RMW (`rst`=0 during RMW_WR) -> `dm_MemWrite` drops at once; the memory word is unchanged; every output is 0.
- Word store 0x00abcdef to 0x1000101C, then word load from 0x1000101C -> `LoadData`=0x00abcdef with `load_valid` one cycle after the load, `stall` never set.
- Memory word 0x00abcdef at 0x10001010; `sb` 0x5A to 0x10001011 -> one cycle of `stall`=1, then the `Data_Mem` word becomes 0x005acdef.
- With that word at 0x10001010:
  - `lb` 0x10001012 -> 0xFFFFFFCD.
  - `lbu` 0x10001012 -> 0x000000CD.
  - `lh` 0x10001012 -> 0xFFFFCDEF.
  - `lhu` 0x10001010 -> 0x0000005A.
- Faults, each with no `dm_*` strobe:
  - `lw` 0x10001002 -> `fault_cause`=01.
  - `sw` 0x00000000 -> `fault_cause`=10.
  - `MemRead`=`MemWrite`=1 at 0x10001010 -> `fault_cause`=11.
  - In each case `fault_addr` equals the request address.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns pipeline memory requests into
// word-aligned Data_Mem accesses, performs read-modify-write for sub-word
// stores, extends load data, and flags rejected requests.
module load_store_unit #(
  parameter logic [31:0] DATA_BASE  = 32'h10001000,
  parameter int          DATA_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  ls_size,
  input  logic        ls_unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic [31:0] dm_Address,
  output logic [31:0] dm_WriteData,
  output logic        dm_MemRead,
  output logic        dm_MemWrite,
  input  logic [31:0] dm_ReadData,
  output logic        stall,
  output logic [31:0] LoadData,
  output logic        load_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  localparam logic [31:0] DATA_BYTES = 32'(4 * DATA_WORDS);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state, state_next;
  logic        req, conflict, misaligned, out_of_range, bad;
  logic        is_word, is_half;
  logic        accept_load, accept_sub_store;
  logic [1:0]  cause_p0;
  logic [31:0] offset_p0;
  logic [31:0] merge_p1;
  logic [29:0] addr_p1;

  // Big-endian lane selection and extension of a loaded word.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    if (size[1])
      return word;
    else if (size == 2'b01)
      return uns ? {16'h0000, h} : {{16{h[15]}}, h};
    else
      return uns ? {24'h000000, b} : {{24{b[7]}}, b};
  endfunction

  // Replace one byte or halfword lane of a word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] m;
    m = word;
    if (size == 2'b01) begin
      if (off[1]) m[15:0]  = data[15:0];
      else        m[31:16] = data[15:0];
    end else begin
      case (off)
        2'd0:    m[31:24] = data[7:0];
        2'd1:    m[23:16] = data[7:0];
        2'd2:    m[15:8]  = data[7:0];
        default: m[7:0]   = data[7:0];
      endcase
    end
    return m;
  endfunction

  assign is_word      = ls_size[1];
  assign is_half      = (ls_size == 2'b01);
  assign req          = ls_valid & (MemRead | MemWrite);
  assign offset_p0    = Address - DATA_BASE;
  assign conflict     = MemRead & MemWrite;
  assign misaligned   = (is_half & Address[0]) | (is_word & (Address[1:0] != 2'b00));
  assign out_of_range = (Address < DATA_BASE) | (offset_p0 >= DATA_BYTES);
  assign bad          = conflict | misaligned | out_of_range;
  assign cause_p0     = conflict ? 2'b11 : (misaligned ? 2'b01 : 2'b10);

  // Requests are only evaluated in IDLE; RMW_WR ignores the request inputs.
  assign accept_load      = (state == IDLE) & req & ~bad & MemRead;
  assign accept_sub_store = (state == IDLE) & req & ~bad & MemWrite & ~is_word;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and Data_Mem strobes; strobes and stall are held low in reset.
  always_comb begin
    state_next   = state;
    dm_Address   = {Address[31:2], 2'b00};
    dm_WriteData = StoreData;
    dm_MemRead   = 1'b0;
    dm_MemWrite  = 1'b0;
    stall        = 1'b0;
    case (state)
      IDLE: begin
        if (req && !bad) begin
          if (MemRead) begin
            dm_MemRead = 1'b1;
          end else if (is_word) begin
            dm_MemWrite = 1'b1;
          end else begin
            dm_MemRead = 1'b1;
            stall      = 1'b1;
            state_next = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        dm_Address   = {addr_p1, 2'b00};
        dm_WriteData = merge_p1;
        dm_MemWrite  = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!rst) begin
      dm_MemRead  = 1'b0;
      dm_MemWrite = 1'b0;
      stall       = 1'b0;
    end
  end

  // ---- stage p1: registered load result, fault report, RMW merge word ----
  // Result and fault registers, pulses cleared when nothing is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LoadData    <= 32'h0;
      load_valid  <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      fault_addr  <= 32'h0;
    end else begin
      load_valid <= accept_load;
      fault      <= (state == IDLE) & req & bad;
      if (accept_load)
        LoadData <= extend_load(dm_ReadData, ls_size, Address[1:0], ls_unsigned);
      if ((state == IDLE) && req && bad) begin
        fault_cause <= cause_p0;
        fault_addr  <= Address;
      end
    end
  end

  // Merge register and held word address for the RMW write cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      merge_p1 <= 32'h0;
      addr_p1  <= 30'h0;
    end else if (accept_sub_store) begin
      merge_p1 <= merge_store(dm_ReadData, StoreData, ls_size, Address[1:0]);
      addr_p1  <= Address[31:2];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural Data_Mem model.
module tb_load_store_unit;

  logic        clk, rst;
  logic        ls_valid, MemRead, MemWrite, ls_unsigned;
  logic [1:0]  ls_size;
  logic [31:0] Address, StoreData;
  logic [31:0] dm_Address, dm_WriteData, dm_ReadData;
  logic        dm_MemRead, dm_MemWrite, stall;
  logic [31:0] LoadData, fault_addr;
  logic        load_valid, fault;
  logic [1:0]  fault_cause;

  load_store_unit dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .ls_size(ls_size), .ls_unsigned(ls_unsigned), .Address(Address), .StoreData(StoreData),
    .dm_Address(dm_Address), .dm_WriteData(dm_WriteData), .dm_MemRead(dm_MemRead),
    .dm_MemWrite(dm_MemWrite), .dm_ReadData(dm_ReadData), .stall(stall),
    .LoadData(LoadData), .load_valid(load_valid), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data segment 0x10001000..0x100013FF: word index is address bits [9:2].
  logic [31:0] mem [0:255];
  logic        dm_in_range;
  assign dm_in_range = (dm_Address[31:10] == 22'h040004);
  assign dm_ReadData = dm_in_range ? mem[dm_Address[9:2]] : 32'hDEADBEEF;
  always @(posedge clk)
    if (dm_MemWrite && dm_in_range) mem[dm_Address[9:2]] <= dm_WriteData;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [1:0]  cause;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:25];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [1:0] cause, input logic [31:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.uns = uns;
    v.addr = addr; v.sdata = sdata; v.cause = cause; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ls_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ls_size = 2'b10;
    ls_unsigned = 1'b0; Address = 32'h0; StoreData = 32'h0;
  endtask

  task automatic drive(input vec_t v);
    ls_valid = 1'b1; MemRead = v.rd; MemWrite = v.wr; ls_size = v.size;
    ls_unsigned = v.uns; Address = v.addr; StoreData = v.sdata;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    drive(v);
    #1;
    if (v.cause != 2'b00) begin
      check($sformatf("v%0d strobes", i), {dm_MemRead, dm_MemWrite, stall}, 3'b000);
    end else if (v.rd) begin
      check($sformatf("v%0d ld strobes", i), {dm_MemRead, dm_MemWrite, stall}, 3'b100);
      check($sformatf("v%0d ld addr", i), dm_Address, {v.addr[31:2], 2'b00});
    end else if (v.size[1]) begin
      check($sformatf("v%0d sw strobes", i), {dm_MemRead, dm_MemWrite, stall}, 3'b010);
      check($sformatf("v%0d sw wdata", i), dm_WriteData, v.sdata);
    end else begin
      check($sformatf("v%0d rmw rd strobes", i), {dm_MemRead, dm_MemWrite, stall}, 3'b101);
    end
    @(posedge clk);
    #1;
    ls_valid = 1'b0;
    if (v.cause != 2'b00) begin
      check($sformatf("v%0d fault", i), {fault, load_valid}, 2'b10);
      check($sformatf("v%0d cause", i), fault_cause, v.cause);
      check($sformatf("v%0d faddr", i), fault_addr, v.addr);
    end else if (v.rd) begin
      check($sformatf("v%0d load_valid", i), {load_valid, fault}, 2'b10);
      check($sformatf("v%0d LoadData", i), LoadData, v.exp);
    end else if (v.size[1]) begin
      check($sformatf("v%0d mem", i), mem[v.addr[9:2]], v.exp);
      check($sformatf("v%0d pulses", i), {load_valid, fault}, 2'b00);
    end else begin
      check($sformatf("v%0d rmw wr strobes", i), {dm_MemRead, dm_MemWrite, stall}, 3'b010);
      check($sformatf("v%0d rmw addr", i), dm_Address, {v.addr[31:2], 2'b00});
      check($sformatf("v%0d rmw wdata", i), dm_WriteData, v.exp);
      @(posedge clk);
      #1;
      check($sformatf("v%0d mem", i), mem[v.addr[9:2]], v.exp);
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d pulse end", i), {load_valid, fault}, 2'b00);
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 2'b10, 0, 32'h1000101C, 32'h00abcdef, 2'b00, 32'h00abcdef);
    vecs[1]  = mk(1, 0, 2'b10, 0, 32'h1000101C, 32'h0,        2'b00, 32'h00abcdef);
    vecs[2]  = mk(0, 1, 2'b10, 0, 32'h10001010, 32'h00abcdef, 2'b00, 32'h00abcdef);
    vecs[3]  = mk(0, 1, 2'b00, 0, 32'h10001011, 32'h0000005A, 2'b00, 32'h005acdef);
    vecs[4]  = mk(1, 0, 2'b00, 0, 32'h10001012, 32'h0,        2'b00, 32'hFFFFFFCD);
    vecs[5]  = mk(1, 0, 2'b00, 1, 32'h10001012, 32'h0,        2'b00, 32'h000000CD);
    vecs[6]  = mk(1, 0, 2'b01, 0, 32'h10001012, 32'h0,        2'b00, 32'hFFFFCDEF);
    vecs[7]  = mk(1, 0, 2'b01, 1, 32'h10001010, 32'h0,        2'b00, 32'h0000005A);
    vecs[8]  = mk(1, 0, 2'b10, 0, 32'h10001002, 32'h0,        2'b01, 32'h0);
    vecs[9]  = mk(0, 1, 2'b10, 0, 32'h00000000, 32'h12345678, 2'b10, 32'h0);
    vecs[10] = mk(1, 1, 2'b10, 0, 32'h10001010, 32'h0,        2'b11, 32'h0);
    vecs[11] = mk(0, 1, 2'b01, 0, 32'h10001012, 32'h1234BEEF, 2'b00, 32'h005abeef);
    vecs[12] = mk(1, 0, 2'b00, 0, 32'h10001011, 32'h0,        2'b00, 32'h0000005A);
    vecs[13] = mk(1, 0, 2'b00, 0, 32'h10001013, 32'h0,        2'b00, 32'hFFFFFFEF);
    vecs[14] = mk(1, 0, 2'b00, 1, 32'h10001013, 32'h0,        2'b00, 32'h000000EF);
    vecs[15] = mk(1, 0, 2'b01, 0, 32'h10001011, 32'h0,        2'b01, 32'h0);
    vecs[16] = mk(0, 1, 2'b10, 0, 32'h100013FC, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D);
    vecs[17] = mk(1, 0, 2'b10, 0, 32'h100013FC, 32'h0,        2'b00, 32'hCAFEF00D);
    vecs[18] = mk(1, 0, 2'b10, 0, 32'h10001400, 32'h0,        2'b10, 32'h0);
    vecs[19] = mk(1, 0, 2'b10, 0, 32'h10000FFC, 32'h0,        2'b10, 32'h0);
    vecs[20] = mk(0, 1, 2'b11, 0, 32'h10001020, 32'h11223344, 2'b00, 32'h11223344);
    vecs[21] = mk(0, 1, 2'b00, 0, 32'h10001020, 32'hFFFFFFA5, 2'b00, 32'hA5223344);
    vecs[22] = mk(0, 1, 2'b00, 0, 32'h10001023, 32'h00000066, 2'b00, 32'hA5223366);
    vecs[23] = mk(1, 0, 2'b11, 0, 32'h10001020, 32'h0,        2'b00, 32'hA5223366);
    vecs[24] = mk(1, 0, 2'b01, 1, 32'h1000101E, 32'h0,        2'b00, 32'h0000CDEF);
    vecs[25] = mk(1, 0, 2'b01, 0, 32'h1000101C, 32'h0,        2'b00, 32'h000000AB);

    // Reset: a valid load request must not reach Data_Mem while rst is low.
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(vecs[1]);
    #1;
    check("reset strobes", {dm_MemRead, dm_MemWrite, stall}, 3'b000);
    check("reset pulses", {load_valid, fault, fault_cause}, 4'b0000);
    check("reset LoadData", LoadData, 32'h0);
    check("reset fault_addr", fault_addr, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 26; i++) run_vec(i);

    // Load issued during RMW_WR is ignored, then evaluated next cycle on the merged word.
    @(negedge clk);
    drive(mk(0, 1, 2'b01, 0, 32'h10001020, 32'h00001357, 2'b00, 32'h0));
    @(posedge clk);
    #1;
    drive(mk(1, 0, 2'b10, 0, 32'h10001020, 32'h0, 2'b00, 32'h0));
    check("rmw->ld wr cycle", {dm_MemRead, dm_MemWrite, stall}, 3'b010);
    @(posedge clk);
    #1;
    check("rmw->ld no early pulse", load_valid, 1'b0);
    check("rmw->ld rd strobe", {dm_MemRead, dm_MemWrite, stall}, 3'b100);
    @(posedge clk);
    #1;
    idle_inputs();
    check("rmw->ld load_valid", load_valid, 1'b1);
    check("rmw->ld LoadData", LoadData, 32'h13573366);

    // Reset asserted in RMW_WR aborts the write.
    @(negedge clk);
    drive(mk(0, 1, 2'b00, 0, 32'h10001021, 32'h00000077, 2'b00, 32'h0));
    @(posedge clk);
    #1;
    idle_inputs();
    check("rstmid wr cycle", dm_MemWrite, 1'b1);
    rst = 1'b0;
    #1;
    check("rstmid strobes", {dm_MemRead, dm_MemWrite, stall}, 3'b000);
    check("rstmid outputs", {load_valid, fault, fault_cause}, 4'b0000);
    check("rstmid LoadData", LoadData, 32'h0);
    check("rstmid fault_addr", fault_addr, 32'h0);
    @(posedge clk);
    #1;
    check("rstmid mem unchanged", mem[8], 32'h13573366);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid after release", {dm_MemRead, dm_MemWrite, stall, load_valid, fault}, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
